// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive engine: frame FSM encoding,
// parity polarity and the default watchdog length.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_DATA       = 3'd2,
    S_PARITY     = 3'd3,
    S_STOP       = 3'd4
  } ps2_state_e;

  // XOR of payload and parity bit must equal this for a good frame.
  localparam logic ODD_PARITY = 1'b1;

  // 1 ms at 50 MHz.
  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through receive FIFO; dout shows the head straight from
// storage. A push while full is accepted only if a pop happens in the same cycle.
module ps2_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      // Pointers wrap naturally because DEPTH is a power of two.
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_frame_fifo.sv
// PS/2 receive engine: start/data/parity/stop capture on ps2_clk_posedge
// strobes, parity/framing/timeout checking, and a FWFT buffer for good frames.
module ps2_rx_frame_fifo
  import ps2_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int PARITY_CHECK   = 1,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wait_for_incoming_data,
  input  logic                          start_receiving_data,
  input  logic                          ps2_clk_posedge,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          err_clear,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          received_data_en,
  output logic                          busy,
  output logic                          parity_error,
  output logic                          framing_error,
  output logic                          timeout_error,
  output logic                          overflow
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BC_W = $clog2(DATA_BITS + 1);

  ps2_state_e           state;
  logic [DATA_BITS-1:0] sr;
  logic [BC_W-1:0]      bit_cnt;
  logic [WD_W-1:0]      wd_cnt;
  logic                 parity_ok;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 frame_good;
  logic                 push;
  logic                 pop;

  assign frame_good = ps2_data && !((PARITY_CHECK != 0) && !parity_ok);
  assign push       = (state == S_STOP) && ps2_clk_posedge && frame_good && (!fifo_full || rd_en);
  assign pop        = rd_en && !fifo_empty;
  assign rd_valid   = !fifo_empty;
  assign busy       = (state != S_IDLE);

  ps2_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (sr),
    .dout  (rd_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      sr               <= '0;
      bit_cnt          <= '0;
      wd_cnt           <= '0;
      parity_ok        <= 1'b0;
      received_data_en <= 1'b0;
      parity_error     <= 1'b0;
      framing_error    <= 1'b0;
      timeout_error    <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      received_data_en <= push;
      // Clear first so a coincident set below wins.
      if (err_clear) begin
        parity_error  <= 1'b0;
        framing_error <= 1'b0;
        timeout_error <= 1'b0;
        overflow      <= 1'b0;
      end
      if (state != S_DATA) bit_cnt <= '0;

      case (state)
        S_IDLE: begin
          wd_cnt <= '0;
          if (wait_for_incoming_data)    state <= S_WAIT_START;
          else if (start_receiving_data) state <= S_DATA;
        end
        S_WAIT_START: begin
          wd_cnt <= '0;
          if (ps2_clk_posedge && !ps2_data) state <= S_DATA;
          else if (!wait_for_incoming_data) state <= S_IDLE;
        end
        S_DATA, S_PARITY, S_STOP: begin
          if (ps2_clk_posedge) begin
            wd_cnt <= '0;
            if (state == S_DATA) begin
              sr <= {ps2_data, sr[DATA_BITS-1:1]};
              if (bit_cnt == BC_W'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
                state   <= S_PARITY;
              end else begin
                bit_cnt <= bit_cnt + BC_W'(1);
              end
            end else if (state == S_PARITY) begin
              parity_ok <= ((^{sr, ps2_data}) == ODD_PARITY);
              state     <= S_STOP;
            end else begin
              state <= S_IDLE;
              if (!ps2_data)                             framing_error <= 1'b1;
              else if ((PARITY_CHECK != 0) && !parity_ok) parity_error  <= 1'b1;
              else if (fifo_full && !rd_en)              overflow      <= 1'b1;
            end
          end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_error <= 1'b1;
            bit_cnt       <= '0;
            wd_cnt        <= '0;
            state         <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame_fifo.sv
// Directed bench for ps2_rx_frame_fifo: default instance plus a second
// instance with parity checking disabled, both on the same stimulus.
module tb_ps2_rx_frame_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wait_for_incoming_data;
  logic       start_receiving_data;
  logic       ps2_clk_posedge;
  logic       ps2_data;
  logic       rd_en;
  logic       err_clear;

  logic [7:0] rd_data,    rd_data_np;
  logic       rd_valid,   rd_valid_np;
  logic [2:0] fifo_count, fifo_count_np;
  logic       received_data_en, received_data_en_np;
  logic       busy, busy_np;
  logic       parity_error, parity_error_np;
  logic       framing_error, framing_error_np;
  logic       timeout_error, timeout_error_np;
  logic       overflow, overflow_np;

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (received_data_en === 1'b1) pulse_cnt++;

  ps2_rx_frame_fifo dut (
    .clk(clk), .reset(reset),
    .wait_for_incoming_data(wait_for_incoming_data),
    .start_receiving_data(start_receiving_data),
    .ps2_clk_posedge(ps2_clk_posedge), .ps2_data(ps2_data),
    .rd_en(rd_en), .err_clear(err_clear),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
    .received_data_en(received_data_en), .busy(busy),
    .parity_error(parity_error), .framing_error(framing_error),
    .timeout_error(timeout_error), .overflow(overflow)
  );

  ps2_rx_frame_fifo #(.PARITY_CHECK(0)) dut_np (
    .clk(clk), .reset(reset),
    .wait_for_incoming_data(wait_for_incoming_data),
    .start_receiving_data(start_receiving_data),
    .ps2_clk_posedge(ps2_clk_posedge), .ps2_data(ps2_data),
    .rd_en(rd_en), .err_clear(err_clear),
    .rd_data(rd_data_np), .rd_valid(rd_valid_np), .fifo_count(fifo_count_np),
    .received_data_en(received_data_en_np), .busy(busy_np),
    .parity_error(parity_error_np), .framing_error(framing_error_np),
    .timeout_error(timeout_error_np), .overflow(overflow_np)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic pop);
    ps2_data        = b;
    ps2_clk_posedge = 1'b1;
    rd_en           = pop;
    tick(1);
    ps2_clk_posedge = 1'b0;
    rd_en           = 1'b0;
    tick(3);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic with_start, input logic pop_at_stop);
    if (with_start) send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
    send_bit(par, 1'b0);
    send_bit(stop, pop_at_stop);
  endtask

  task automatic do_reset();
    wait_for_incoming_data = 1'b0;
    start_receiving_data   = 1'b0;
    ps2_clk_posedge        = 1'b0;
    ps2_data               = 1'b1;
    rd_en                  = 1'b0;
    err_clear              = 1'b0;
    reset                  = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(1);
    total++;
    if ({rd_data, rd_valid, fifo_count, received_data_en, busy} !== 13'h0) begin
      bad++;
      $display("FAIL reset_outputs: got data=%h valid=%b count=%0d pulse=%b busy=%b want all 0",
               rd_data, rd_valid, fifo_count, received_data_en, busy);
    end
    total++;
    if ({parity_error, framing_error, timeout_error, overflow} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b%b%b%b want 0000",
               parity_error, framing_error, timeout_error, overflow);
    end
    do_reset();
  endtask

  task automatic test_good_frame();
    int p0;
    do_reset();
    wait_for_incoming_data = 1'b1;
    tick(2);
    p0 = pulse_cnt;
    send_bit(1'b0, 1'b0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL good_busy: got %b want 1", busy); end
    for (int i = 0; i < 8; i++) send_bit(i inside {2, 3, 4}, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    total++;
    if (pulse_cnt - p0 !== 1) begin bad++; $display("FAIL good_pulse: got %0d want 1", pulse_cnt - p0); end
    total++;
    if (rd_valid !== 1'b1) begin bad++; $display("FAIL good_valid: got %b want 1", rd_valid); end
    total++;
    if (rd_data !== 8'h1C) begin bad++; $display("FAIL good_data: got %h want 1c", rd_data); end
    total++;
    if (fifo_count !== 3'd1) begin bad++; $display("FAIL good_count: got %0d want 1", fifo_count); end
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL good_pop: got valid=%b count=%0d want 0 0", rd_valid, fifo_count);
    end
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    total++;
    if (fifo_count !== 3'd0) begin bad++; $display("FAIL pop_empty: got %0d want 0", fifo_count); end
  endtask

  task automatic test_parity_error();
    int p0;
    do_reset();
    wait_for_incoming_data = 1'b1;
    tick(2);
    p0 = pulse_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b1, 1'b0);
    total++;
    if (parity_error !== 1'b1) begin bad++; $display("FAIL parity_flag: got %b want 1", parity_error); end
    total++;
    if (fifo_count !== 3'd0 || pulse_cnt != p0) begin
      bad++;
      $display("FAIL parity_drop: got count=%0d pulses=%0d want 0 0", fifo_count, pulse_cnt - p0);
    end
    total++;
    if (rd_valid_np !== 1'b1 || rd_data_np !== 8'h1C) begin
      bad++;
      $display("FAIL noparity_data: got valid=%b data=%h want 1 1c", rd_valid_np, rd_data_np);
    end
    total++;
    if (parity_error_np !== 1'b0) begin bad++; $display("FAIL noparity_flag: got %b want 0", parity_error_np); end
  endtask

  task automatic test_framing_error();
    do_reset();
    wait_for_incoming_data = 1'b1;
    tick(2);
    send_frame(8'hF0, 1'b1, 1'b0, 1'b1, 1'b0);
    total++;
    if (framing_error !== 1'b1) begin bad++; $display("FAIL framing_flag: got %b want 1", framing_error); end
    total++;
    if (fifo_count !== 3'd0 || parity_error !== 1'b0) begin
      bad++;
      $display("FAIL framing_drop: got count=%0d perr=%b want 0 0", fifo_count, parity_error);
    end
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    total++;
    if ({parity_error, framing_error, timeout_error, overflow} !== 4'b0) begin
      bad++;
      $display("FAIL err_clear: got %b%b%b%b want 0000",
               parity_error, framing_error, timeout_error, overflow);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    wait_for_incoming_data = 1'b1;
    tick(2);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    wait_for_incoming_data = 1'b0;
    // Last strobe was 3 edges ago; the flag must not appear before edge 50000.
    tick(49990);
    total++;
    if (timeout_error !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early: got terr=%b busy=%b want 0 1", timeout_error, busy);
    end
    tick(20);
    total++;
    if (timeout_error !== 1'b1) begin bad++; $display("FAIL timeout_flag: got %b want 1", timeout_error); end
    total++;
    if (busy !== 1'b0 || fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL timeout_idle: got busy=%b count=%0d want 0 0", busy, fifo_count);
    end
    wait_for_incoming_data = 1'b1;
    tick(2);
    send_frame(8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h55) begin
      bad++;
      $display("FAIL timeout_recover: got valid=%b data=%h want 1 55", rd_valid, rd_data);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    wait_for_incoming_data = 1'b1;
    tick(2);
    send_frame(8'h11, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b1, 1'b1, 1'b0);
    total++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_fill: got count=%0d ovf=%b want 4 0", fifo_count, overflow);
    end
    send_frame(8'h66, 1'b1, 1'b1, 1'b1, 1'b0);
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    total++;
    if (fifo_count !== 3'd4 || rd_data !== 8'h11) begin
      bad++;
      $display("FAIL ovf_keep: got count=%0d head=%h want 4 11", fifo_count, rd_data);
    end

    do_reset();
    wait_for_incoming_data = 1'b1;
    tick(2);
    send_frame(8'h11, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h66, 1'b1, 1'b1, 1'b1, 1'b1);
    total++;
    if (overflow !== 1'b0 || fifo_count !== 3'd4 || rd_data !== 8'h22) begin
      bad++;
      $display("FAIL ovf_pushpop: got ovf=%b count=%0d head=%h want 0 4 22",
               overflow, fifo_count, rd_data);
    end
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      tick(1);
    end
    rd_en = 1'b0;
    total++;
    if (rd_data !== 8'h66 || fifo_count !== 3'd1) begin
      bad++;
      $display("FAIL ovf_tail: got head=%h count=%0d want 66 1", rd_data, fifo_count);
    end
  endtask

  task automatic test_reset_midframe();
    int p0;
    do_reset();
    wait_for_incoming_data = 1'b1;
    tick(2);
    send_frame(8'h33, 1'b1, 1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    reset = 1'b0;
    #1;
    total++;
    if ({busy, rd_valid, fifo_count, rd_data} !== 13'h0) begin
      bad++;
      $display("FAIL midreset_outputs: got busy=%b valid=%b count=%0d data=%h want all 0",
               busy, rd_valid, fifo_count, rd_data);
    end
    tick(1);
    reset = 1'b1;
    tick(2);
    p0 = pulse_cnt;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
    total++;
    if (rd_data !== 8'hA5 || fifo_count !== 3'd1 || pulse_cnt - p0 != 1) begin
      bad++;
      $display("FAIL midreset_frame: got data=%h count=%0d pulses=%0d want a5 1 1",
               rd_data, fifo_count, pulse_cnt - p0);
    end
    total++;
    if ({parity_error, framing_error, timeout_error, overflow} !== 4'b0) begin
      bad++;
      $display("FAIL midreset_flags: got %b%b%b%b want 0000",
               parity_error, framing_error, timeout_error, overflow);
    end
  endtask

  task automatic test_start_receiving();
    do_reset();
    start_receiving_data = 1'b1;
    tick(1);
    start_receiving_data = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL direct_busy: got %b want 1", busy); end
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || busy !== 1'b0) begin
      bad++;
      $display("FAIL direct_frame: got valid=%b data=%h busy=%b want 1 a5 0",
               rd_valid, rd_data, busy);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_framing_error();
    test_timeout();
    test_overflow();
    test_reset_midframe();
    test_start_receiving();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
